// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit.
package multicycle_ctrl_pkg;

  localparam int unsigned OPCODE_W  = 7;
  localparam int unsigned FUNC3_W   = 3;
  localparam int unsigned FUNC7_W   = 7;
  localparam int unsigned ALUCTL_W  = 3;
  localparam int unsigned SEL_W     = 2;
  localparam int unsigned STATE_W   = 4;

  // Controller states
  typedef enum logic [STATE_W-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    HALT     = 4'd11
  } state_t;

  // Supported opcodes
  localparam logic [OPCODE_W-1:0] OP_LW    = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_ITYPE = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL   = 7'b1101111;

  // Internal ALU operation class
  typedef enum logic [SEL_W-1:0] {
    ALUOP_ADD  = 2'b00,
    ALUOP_SUB  = 2'b01,
    ALUOP_FUNC = 2'b10
  } alu_op_t;

  // func3 values decoded for ALU operations
  localparam logic [FUNC3_W-1:0] F3_ADDSUB = 3'b000;
  localparam logic [FUNC3_W-1:0] F3_SLT    = 3'b010;
  localparam logic [FUNC3_W-1:0] F3_OR     = 3'b110;
  localparam logic [FUNC3_W-1:0] F3_AND    = 3'b111;

  // ALUControl encodings
  localparam logic [ALUCTL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUCTL_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALUCTL_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALUCTL_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALUCTL_W-1:0] ALU_SLT = 3'b101;

  // ImmSrc encodings
  localparam logic [SEL_W-1:0] IMM_I = 2'b00;
  localparam logic [SEL_W-1:0] IMM_S = 2'b01;
  localparam logic [SEL_W-1:0] IMM_B = 2'b10;
  localparam logic [SEL_W-1:0] IMM_J = 2'b11;

  // ResultSrc encodings
  localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b00;
  localparam logic [SEL_W-1:0] RES_READDATA  = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b10;

  // ALUSrcA encodings
  localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_RD1   = 2'b10;

  // ALUSrcB encodings
  localparam logic [SEL_W-1:0] SRCB_RD2  = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

  // Immediate format is a pure function of the opcode in every state
  function automatic logic [SEL_W-1:0] imm_src_of(input logic [OPCODE_W-1:0] op);
    logic [SEL_W-1:0] sel;
    sel = IMM_I;
    case (op)
      OP_SW:   sel = IMM_S;
      OP_BEQ:  sel = IMM_B;
      OP_JAL:  sel = IMM_J;
      default: sel = IMM_I;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: operation class plus instruction fields to ALUControl.
module alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  alu_op_t              i_alu_op,
  input  logic [FUNC3_W-1:0]   i_func3,
  input  logic                 i_func7b5,
  input  logic                 i_op5,
  output logic [ALUCTL_W-1:0]  o_alu_control_c
);

  // Only register-register add/sub uses func7[5]; immediate forms are always add
  always_comb begin
    o_alu_control_c = ALU_ADD;
    case (i_alu_op)
      ALUOP_ADD: o_alu_control_c = ALU_ADD;
      ALUOP_SUB: o_alu_control_c = ALU_SUB;
      ALUOP_FUNC: begin
        case (i_func3)
          F3_ADDSUB: o_alu_control_c = (i_op5 & i_func7b5) ? ALU_SUB : ALU_ADD;
          F3_SLT:    o_alu_control_c = ALU_SLT;
          F3_OR:     o_alu_control_c = ALU_OR;
          F3_AND:    o_alu_control_c = ALU_AND;
          default:   o_alu_control_c = ALU_ADD;
        endcase
      end
      default: o_alu_control_c = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore main controller for the multicycle RV32I datapath.
module multicycle_control_fsm
  import multicycle_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic [FUNC3_W-1:0]   func3,
  input  logic [FUNC7_W-1:0]   func7,
  input  logic                 Zero,
  input  logic                 mem_ready,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic                 AdrSrc,
  output logic [SEL_W-1:0]     ResultSrc,
  output logic [SEL_W-1:0]     ALUSrcA,
  output logic [SEL_W-1:0]     ALUSrcB,
  output logic [SEL_W-1:0]     ImmSrc,
  output logic [ALUCTL_W-1:0]  ALUControl,
  output logic                 retire,
  output logic                 illegal_op,
  output logic                 halted
);

  state_t           r_state;
  state_t           w_next;
  state_t           w_view;
  alu_op_t          w_alu_op;
  logic             w_pc_update;
  logic             w_branch;
  logic             w_gate;
  logic             w_irwrite;
  logic             w_memwrite;
  logic             w_regwrite;
  logic             w_adr_src;
  logic [SEL_W-1:0] w_result_src;
  logic [SEL_W-1:0] w_srca;
  logic [SEL_W-1:0] w_srcb;
  logic             w_retire;
  logic             w_illegal;
  logic             w_halted;
  logic             w_unused_func7;

  // While reset is high the outputs decode as FETCH regardless of the stored state
  assign w_view = reset ? FETCH : r_state;

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and per-state control decode
  always_comb begin
    w_next       = w_view;
    w_alu_op     = ALUOP_ADD;
    w_pc_update  = 1'b0;
    w_branch     = 1'b0;
    w_gate       = 1'b1;
    w_irwrite    = 1'b0;
    w_memwrite   = 1'b0;
    w_regwrite   = 1'b0;
    w_adr_src    = 1'b0;
    w_result_src = RES_ALURESULT;
    w_srca       = SRCA_PC;
    w_srcb       = SRCB_RD2;
    w_retire     = 1'b0;
    w_illegal    = 1'b0;
    w_halted     = 1'b0;

    case (w_view)
      FETCH: begin
        w_adr_src   = 1'b0;
        w_srca      = SRCA_PC;
        w_srcb      = SRCB_FOUR;
        w_alu_op    = ALUOP_ADD;
        w_irwrite   = mem_ready;
        w_pc_update = 1'b1;
        w_gate      = mem_ready;
        w_next      = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        // Branch target PC+imm computed here and parked in ALUOut
        w_srca   = SRCA_OLDPC;
        w_srcb   = SRCB_IMM;
        w_alu_op = ALUOP_ADD;
        case (opcode)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_RTYPE:     w_next = EXECUTER;
          OP_ITYPE:     w_next = EXECUTEI;
          OP_BEQ:       w_next = BEQ;
          OP_JAL:       w_next = JAL;
          default: begin
            w_illegal = 1'b1;
            w_next    = ILLEGAL_HALT ? HALT : FETCH;
          end
        endcase
      end
      MEMADR: begin
        w_srca   = SRCA_RD1;
        w_srcb   = SRCB_IMM;
        w_alu_op = ALUOP_ADD;
        w_next   = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        w_adr_src    = 1'b1;
        w_result_src = RES_ALUOUT;
        w_next       = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        w_result_src = RES_READDATA;
        w_regwrite   = 1'b1;
        w_retire     = 1'b1;
        w_next       = FETCH;
      end
      MEMWRITE: begin
        // Write strobe only in the completing cycle, so exactly one per store
        w_adr_src    = 1'b1;
        w_result_src = RES_ALUOUT;
        w_memwrite   = mem_ready;
        w_retire     = mem_ready;
        w_next       = mem_ready ? FETCH : MEMWRITE;
      end
      EXECUTER: begin
        w_srca   = SRCA_RD1;
        w_srcb   = SRCB_RD2;
        w_alu_op = ALUOP_FUNC;
        w_next   = ALUWB;
      end
      EXECUTEI: begin
        w_srca   = SRCA_RD1;
        w_srcb   = SRCB_IMM;
        w_alu_op = ALUOP_FUNC;
        w_next   = ALUWB;
      end
      ALUWB: begin
        w_result_src = RES_ALUOUT;
        w_regwrite   = 1'b1;
        w_retire     = 1'b1;
        w_next       = FETCH;
      end
      BEQ: begin
        w_srca       = SRCA_RD1;
        w_srcb       = SRCB_RD2;
        w_alu_op     = ALUOP_SUB;
        w_result_src = RES_ALUOUT;
        w_branch     = 1'b1;
        w_retire     = 1'b1;
        w_next       = FETCH;
      end
      JAL: begin
        // Jump target from ALUOut; OldPC+4 computed now for the link write
        w_srca       = SRCA_OLDPC;
        w_srcb       = SRCB_FOUR;
        w_alu_op     = ALUOP_ADD;
        w_result_src = RES_ALUOUT;
        w_pc_update  = 1'b1;
        w_next       = ALUWB;
      end
      HALT: begin
        w_halted = 1'b1;
        w_next   = HALT;
      end
      default: begin
        w_next = FETCH;
      end
    endcase
  end

  // ALU function decode
  alu_decoder u_alu_decoder (
    .i_alu_op        (w_alu_op),
    .i_func3         (func3),
    .i_func7b5       (func7[5]),
    .i_op5           (opcode[5]),
    .o_alu_control_c (ALUControl)
  );

  // Only func7[5] participates in decode
  assign w_unused_func7 = ^{func7[6], func7[4:0]};

  // Write enables and pulses are suppressed while reset is asserted
  assign IRWrite    = w_irwrite & ~reset;
  assign PCWrite    = ((w_pc_update & w_gate) | (w_branch & Zero)) & ~reset;
  assign MemWrite   = w_memwrite & ~reset;
  assign RegWrite   = w_regwrite & ~reset;
  assign retire     = w_retire & ~reset;
  assign illegal_op = w_illegal & ~reset;
  assign halted     = w_halted;
  assign AdrSrc     = w_adr_src;
  assign ResultSrc  = w_result_src;
  assign ALUSrcA    = w_srca;
  assign ALUSrcB    = w_srcb;
  assign ImmSrc     = imm_src_of(opcode);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm against an instruction-level cycle model.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset, Zero, mem_ready;
  logic [6:0] opcode, func7;
  logic [2:0] func3;
  logic       IRWrite, PCWrite, MemWrite, RegWrite, AdrSrc, retire, illegal_op, halted;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.ILLEGAL_HALT(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func3(func3), .func7(func7),
    .Zero(Zero), .mem_ready(mem_ready), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .retire(retire), .illegal_op(illegal_op), .halted(halted)
  );

  typedef struct packed {
    logic ir, pc, mw, rw, adr;
    logic [1:0] res, sa, sb, imm;
    logic [2:0] alu;
    logic ret, ill, hlt;
  } outs_t;

  typedef struct packed {
    logic rst, mr, z;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    outs_t exp;
  } cyc_t;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;
  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BEQ = 4, K_JAL = 5, K_ILL = 6;

  int n_tests = 0;
  int n_fail  = 0;
  cyc_t q[$];
  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic [6:0] cur_f7;

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] op);
    if (op == SW) return 2'b01;
    if (op == BQ) return 2'b10;
    if (op == JL) return 2'b11;
    return 2'b00;
  endfunction

  // ALU function selected by instruction fields for register/immediate ALU ops
  function automatic logic [2:0] alu_fn(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    if (f3 == 3'b000) return (op[5] && f7[5]) ? 3'b001 : 3'b000;
    if (f3 == 3'b010) return 3'b101;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b111) return 3'b010;
    return 3'b000;
  endfunction

  function automatic outs_t blank();
    outs_t o;
    o = '0;
    o.imm = imm_of(cur_op);
    return o;
  endfunction

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    cur_op = op; cur_f3 = f3; cur_f7 = f7;
  endtask

  task automatic push(input logic rst, input logic mr, input logic z, input outs_t o);
    cyc_t c;
    c.rst = rst; c.mr = mr; c.z = z;
    c.op = cur_op; c.f3 = cur_f3; c.f7 = cur_f7;
    c.exp = o;
    q.push_back(c);
  endtask

  task automatic add_fetch(input int stalls);
    outs_t o;
    for (int i = 0; i < stalls; i++) begin
      o = blank(); o.sb = 2'b10;
      push(1'b0, 1'b0, rbit(), o);
    end
    o = blank(); o.sb = 2'b10; o.ir = 1'b1; o.pc = 1'b1;
    push(1'b0, 1'b1, rbit(), o);
  endtask

  task automatic add_reset(input logic mr);
    outs_t o;
    o = blank(); o.sb = 2'b10;
    push(1'b1, mr, rbit(), o);
  endtask

  task automatic add_aluwb();
    outs_t o;
    o = blank(); o.res = 2'b10; o.rw = 1'b1; o.ret = 1'b1;
    push(1'b0, rbit(), rbit(), o);
  endtask

  // One whole instruction as a list of expected cycles; mst = memory stalls or halt cycles
  task automatic add_instr(input int kind, input int fst, input int mst, input logic bz);
    outs_t o;
    add_fetch(fst);
    o = blank(); o.sa = 2'b01; o.sb = 2'b01; o.ill = (kind == K_ILL);
    push(1'b0, rbit(), rbit(), o);
    if (kind == K_LW || kind == K_SW) begin
      o = blank(); o.sa = 2'b10; o.sb = 2'b01;
      push(1'b0, rbit(), rbit(), o);
      for (int i = 0; i <= mst; i++) begin
        o = blank(); o.adr = 1'b1; o.res = 2'b10;
        if (kind == K_SW && i == mst) begin o.mw = 1'b1; o.ret = 1'b1; end
        push(1'b0, (i == mst), rbit(), o);
      end
      if (kind == K_LW) begin
        o = blank(); o.res = 2'b01; o.rw = 1'b1; o.ret = 1'b1;
        push(1'b0, rbit(), rbit(), o);
      end
    end else if (kind == K_R || kind == K_I) begin
      o = blank(); o.sa = 2'b10; o.sb = (kind == K_I) ? 2'b01 : 2'b00;
      o.alu = alu_fn(cur_op, cur_f3, cur_f7);
      push(1'b0, rbit(), rbit(), o);
      add_aluwb();
    end else if (kind == K_BEQ) begin
      o = blank(); o.sa = 2'b10; o.alu = 3'b001; o.res = 2'b10; o.ret = 1'b1; o.pc = bz;
      push(1'b0, rbit(), bz, o);
    end else if (kind == K_JAL) begin
      o = blank(); o.sa = 2'b01; o.sb = 2'b10; o.res = 2'b10; o.pc = 1'b1;
      push(1'b0, rbit(), rbit(), o);
      add_aluwb();
    end else begin
      for (int i = 0; i < mst; i++) begin
        o = blank(); o.hlt = 1'b1;
        push(1'b0, rbit(), rbit(), o);
      end
      add_reset(rbit());
    end
  endtask

  task automatic drive_cycle(input cyc_t c, output outs_t o);
    @(negedge clk);
    reset = c.rst; mem_ready = c.mr; Zero = c.z;
    opcode = c.op; func3 = c.f3; func7 = c.f7;
    #1;
    o = {IRWrite, PCWrite, MemWrite, RegWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB,
         ImmSrc, ALUControl, retire, illegal_op, halted};
  endtask

  task automatic test_reset();
    outs_t obs;
    q.delete();
    set_instr(LW, 3'b000, 7'b0);
    add_reset(1'b1);
    add_reset(1'b0);
    foreach (q[i]) begin
      drive_cycle(q[i], obs);
      n_tests++;
      if (obs !== q[i].exp) begin
        n_fail++;
        $display("FAIL reset cyc%0d got %b want %b", i, obs, q[i].exp);
      end
    end
  endtask

  task automatic test_lw();
    outs_t obs;
    int rets;
    rets = 0;
    q.delete();
    set_instr(LW, 3'b010, 7'b0);
    add_instr(K_LW, 0, 0, 1'b0);
    foreach (q[i]) begin
      drive_cycle(q[i], obs);
      rets += int'(obs.ret);
      n_tests++;
      if (obs !== q[i].exp) begin
        n_fail++;
        $display("FAIL lw cyc%0d got %b want %b", i, obs, q[i].exp);
      end
    end
    n_tests++;
    if (rets !== 1 || q.size() !== 5) begin
      n_fail++;
      $display("FAIL lw_retire got %0d pulses in %0d cycles want 1 in 5", rets, q.size());
    end
  endtask

  task automatic test_alu_ops();
    outs_t obs;
    q.delete();
    set_instr(RT, 3'b000, 7'b0000000); add_instr(K_R, 0, 0, 1'b0);
    set_instr(RT, 3'b000, 7'b0100000); add_instr(K_R, 0, 0, 1'b0);
    set_instr(IT, 3'b000, 7'b0100000); add_instr(K_I, 1, 0, 1'b0);
    set_instr(RT, 3'b010, 7'b0000000); add_instr(K_R, 0, 0, 1'b0);
    set_instr(IT, 3'b110, 7'b0000000); add_instr(K_I, 0, 0, 1'b0);
    set_instr(RT, 3'b111, 7'b0100000); add_instr(K_R, 0, 0, 1'b0);
    set_instr(RT, 3'b001, 7'b0100000); add_instr(K_R, 0, 0, 1'b0);
    foreach (q[i]) begin
      drive_cycle(q[i], obs);
      n_tests++;
      if (obs !== q[i].exp) begin
        n_fail++;
        $display("FAIL alu_ops cyc%0d got %b want %b", i, obs, q[i].exp);
      end
    end
  endtask

  task automatic test_beq();
    outs_t obs;
    q.delete();
    set_instr(BQ, 3'b001, 7'b0); add_instr(K_BEQ, 0, 0, 1'b1);
    set_instr(BQ, 3'b000, 7'b0); add_instr(K_BEQ, 2, 0, 1'b0);
    foreach (q[i]) begin
      drive_cycle(q[i], obs);
      n_tests++;
      if (obs !== q[i].exp) begin
        n_fail++;
        $display("FAIL beq cyc%0d got %b want %b", i, obs, q[i].exp);
      end
    end
  endtask

  task automatic test_sw_stall();
    outs_t obs;
    int writes;
    writes = 0;
    q.delete();
    set_instr(SW, 3'b010, 7'b0);
    add_instr(K_SW, 0, 3, 1'b0);
    set_instr(RT, 3'b000, 7'b0);
    add_instr(K_R, 0, 0, 1'b0);
    foreach (q[i]) begin
      drive_cycle(q[i], obs);
      writes += int'(obs.mw);
      n_tests++;
      if (obs !== q[i].exp) begin
        n_fail++;
        $display("FAIL sw_stall cyc%0d got %b want %b", i, obs, q[i].exp);
      end
    end
    n_tests++;
    if (writes !== 1) begin
      n_fail++;
      $display("FAIL sw_memwrite_count got %0d want 1", writes);
    end
  endtask

  task automatic test_jal();
    outs_t obs;
    q.delete();
    set_instr(JL, 3'b101, 7'b1010101);
    add_instr(K_JAL, 1, 0, 1'b0);
    foreach (q[i]) begin
      drive_cycle(q[i], obs);
      n_tests++;
      if (obs !== q[i].exp) begin
        n_fail++;
        $display("FAIL jal cyc%0d got %b want %b", i, obs, q[i].exp);
      end
    end
  endtask

  // Illegal opcode halts until reset; reset also aborts a stalled load
  task automatic test_illegal_and_abort();
    outs_t obs;
    outs_t o;
    q.delete();
    set_instr(7'b1111111, 3'b000, 7'b0);
    add_instr(K_ILL, 0, 3, 1'b0);
    set_instr(LW, 3'b010, 7'b0);
    add_fetch(0);
    o = blank(); o.sa = 2'b01; o.sb = 2'b01; push(1'b0, 1'b1, 1'b0, o);
    o = blank(); o.sa = 2'b10; o.sb = 2'b01; push(1'b0, 1'b1, 1'b0, o);
    o = blank(); o.adr = 1'b1; o.res = 2'b10;
    push(1'b0, 1'b0, 1'b0, o);
    push(1'b0, 1'b0, 1'b1, o);
    add_reset(1'b1);
    set_instr(SW, 3'b010, 7'b0);
    add_instr(K_SW, 1, 0, 1'b0);
    foreach (q[i]) begin
      drive_cycle(q[i], obs);
      n_tests++;
      if (obs !== q[i].exp) begin
        n_fail++;
        $display("FAIL illegal_abort cyc%0d got %b want %b", i, obs, q[i].exp);
      end
    end
  endtask

  task automatic test_random();
    outs_t obs;
    int kind;
    logic [6:0] op;
    q.delete();
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 6));
      case (kind)
        K_LW:    op = LW;
        K_SW:    op = SW;
        K_R:     op = RT;
        K_I:     op = IT;
        K_BEQ:   op = BQ;
        K_JAL:   op = JL;
        default: begin
          op = 7'($urandom_range(0, 127));
          while (op == LW || op == SW || op == RT || op == IT || op == BQ || op == JL)
            op = 7'($urandom_range(0, 127));
        end
      endcase
      set_instr(op, 3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)));
      add_instr(kind, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rbit());
    end
    foreach (q[i]) begin
      drive_cycle(q[i], obs);
      n_tests++;
      if (obs !== q[i].exp) begin
        n_fail++;
        $display("FAIL random cyc%0d op=%b got %b want %b", i, q[i].op, obs, q[i].exp);
      end
    end
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0; Zero = 1'b0;
    opcode = LW; func3 = 3'b000; func7 = 7'b0;
    test_reset();
    test_lw();
    test_alu_ops();
    test_beq();
    test_sw_stall();
    test_jal();
    test_illegal_and_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Main control unit for the multicycle RV32I datapath (program counter, instruction fetch register, register file, extend, ALU, ALUOut register, SrcA/SrcB/Result muxes, shared instruction/data memory). It replaces the hand-driven control stimulus with a Moore state machine that sequences fetch, decode, execute, memory and writeback for lw, sw, R-type, I-type ALU, beq and jal. It generates every datapath select and write enable from opcode, func3, func7, Zero and a memory-ready handshake.

Parameters:
ILLEGAL_HALT, 0, 1: an unsupported opcode in DECODE enters HALT until reset; 0: it returns to FETCH with no side effect.

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high; sampled on the rising edge of clk
opcode  in  7  instruction bits [6:0] from the instruction register
func3  in  3  instruction bits [14:12]
func7  in  7  instruction bits [31:25]
Zero  in  1  ALU zero flag
mem_ready  in  1  memory access completes this cycle; tie to 1 for combinational memory
IRWrite  out  1  instruction register / OldPC load
PCWrite  out  1  PC load
MemWrite  out  1  memory write enable
RegWrite  out  1  register file write enable
AdrSrc  out  1  address select: 0 = PC, 1 = Result
ResultSrc  out  2  00 = ALUResult, 01 = ReadData, 10 = ALUOut
ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = RD1
ALUSrcB  out  2  00 = RD2, 01 = ImmExt, 10 = constant 4
ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J
ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
retire  out  1  one-cycle pulse in the final cycle of each instruction
illegal_op  out  1  one-cycle pulse in DECODE on an unsupported opcode
halted  out  1  high while in HALT

Behaviour:
- Outputs are a combinational decode of the state register (Moore), except for three qualified outputs: PCWrite in BEQ depends on Zero; handshake-qualified enables depend on mem_ready; ALUControl depends on func3/func7.
- Reset: on a clk edge with reset=1, state <= FETCH. While reset=1, IRWrite, PCWrite, MemWrite, RegWrite, retire and illegal_op are forced to 0. All other outputs take their FETCH values. halted=0.
- PCWrite = (PCUpdate & gate) | (Branch & Zero), where PCUpdate and Branch are internal per-state signals.
- ALUOp is an internal 2-bit per-state signal: 00 add, 01 sub, 10 function decode.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=00. IRWrite=PCWrite=mem_ready. Holds while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Transitions:
  - lw 0000011 or sw 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - any other opcode -> illegal_op=1, then HALT if ILLEGAL_HALT=1, else FETCH.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Goes to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: AdrSrc=1, ResultSrc=10. Holds until mem_ready, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, retire=1. Goes to FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=10. MemWrite=mem_ready and retire=mem_ready. Holds until mem_ready, then goes to FETCH. MemWrite must never be high in two consecutive cycles for one sw.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Both go to ALUWB.
- ALUWB: ResultSrc=10, RegWrite=1, retire=1. Goes to FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=10, Branch=1, retire=1. Goes to FETCH. beq is the only branch decoded; func3 is ignored.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1. Goes to ALUWB, which writes OldPC+4 held in ALUOut.
- ImmSrc by opcode in every state: sw 01, beq 10, jal 11, otherwise 00.
- ALU decode when ALUOp=10, by func3:
  - 000: sub if (opcode[5] & func7[5]), else add
  - 010: slt
  - 110: or
  - 111: and
  - anything else: add
- Default for all outputs not listed in a state: 0 / 00.
- Reset asserted mid-instruction (including during a mem_ready stall) aborts it: no write enable is asserted in that cycle, and the next state is FETCH.
- HALT: all enables 0, halted=1; exits only on reset.

Decomposition:
- Package multicycle_ctrl_pkg holds:
  - state enum: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, HALT
  - opcode constants
  - ALUOp, ALUControl, ImmSrc and mux-select encodings
- One sub-module, alu_decoder: combinational (ALUOp, func3, func7[5], opcode[5]) -> ALUControl.

Test Plan:
- Reset, then lw (opcode 0000011, mem_ready=1): state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 with ResultSrc=01 in cycle 5; retire pulses once; 5 cycles total.
- add then sub (opcode 0110011, func3 000, func7 0000000 / 0100000): ALUControl=000 / 001 in EXECUTER; ALUWB RegWrite=1; 4 cycles each.
- beq with Zero=1, then with Zero=0: PCWrite=1 / 0 in BEQ; ALUControl=001; 3 cycles each.
- sw with mem_ready held low 3 cycles in MEMWRITE: MemWrite=0 while stalled, exactly one MemWrite=1 cycle when mem_ready rises, then FETCH.
- jal: JAL state shows PCWrite=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10; ALUWB RegWrite=1; ImmSrc=11.
- Opcode 1111111 with ILLEGAL_HALT=1: illegal_op pulses, halted=1, no enables. Assert reset in the HALT state and, separately, mid-MEMREAD: the next state is FETCH and no writes occur in the reset cycle.
